// File: rtl/parent_pair_picker.sv
// Draws pairs of distinct in-range parent indices from the upstream random
// generator, resampling bad draws and substituting a rotating fallback pair.
module parent_pair_picker #(
  parameter int IDX_W     = 5,
  parameter int POP_SIZE  = 20,
  parameter int MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [IDX_W-1:0] rand_a,
  input  logic [IDX_W-1:0] rand_b,
  output logic             pair_valid,
  input  logic             pair_ready,
  output logic [IDX_W-1:0] parent_a,
  output logic [IDX_W-1:0] parent_b,
  output logic             fallback,
  output logic             busy,
  output logic [15:0]      reject_cnt
);

  // state  | meaning
  // IDLE   | waiting for req
  // SAMPLE | evaluating one draw per cycle
  // HOLD   | pair presented, waiting for pair_ready
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SAMPLE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
  // One extra bit so POP_SIZE == 2**IDX_W is representable.
  localparam logic [IDX_W:0]   POP_LIM  = (IDX_W + 1)'(POP_SIZE);
  localparam logic [IDX_W-1:0] POP_LAST = IDX_W'(POP_SIZE - 1);

  logic [1:0]       state_q, state_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [IDX_W-1:0] fb_ptr_q, fb_ptr_d;
  logic [IDX_W-1:0] parent_a_q, parent_a_d;
  logic [IDX_W-1:0] parent_b_q, parent_b_d;
  logic             fallback_q, fallback_d;
  logic             pair_valid_q, pair_valid_d;
  logic [15:0]      reject_cnt_q, reject_cnt_d;

  logic             good;
  logic             handshake;
  logic [IDX_W-1:0] fb_next;

  assign good = ({1'b0, rand_a} < POP_LIM) && ({1'b0, rand_b} < POP_LIM)
                && (rand_a != rand_b);
  assign handshake = pair_valid_q & pair_ready;
  assign fb_next   = (fb_ptr_q == POP_LAST) ? '0 : fb_ptr_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    tries_d      = tries_q;
    fb_ptr_d     = fb_ptr_q;
    parent_a_d   = parent_a_q;
    parent_b_d   = parent_b_q;
    fallback_d   = fallback_q;
    reject_cnt_d = reject_cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SAMPLE;
          tries_d = '0;
        end
      end
      SAMPLE: begin
        if (good) begin
          parent_a_d = rand_a;
          parent_b_d = rand_b;
          fallback_d = 1'b0;
          state_d    = HOLD;
        end else begin
          if (reject_cnt_q != 16'hFFFF) reject_cnt_d = reject_cnt_q + 16'd1;
          if (tries_q == TRY_LAST) begin
            parent_a_d = fb_ptr_q;
            parent_b_d = fb_next;
            fallback_d = 1'b1;
            fb_ptr_d   = fb_next;
            state_d    = HOLD;
          end else begin
            tries_d = tries_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (handshake) begin
          state_d = req ? SAMPLE : IDLE;
          tries_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    pair_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tries_q      <= '0;
      fb_ptr_q     <= '0;
      parent_a_q   <= '0;
      parent_b_q   <= '0;
      fallback_q   <= 1'b0;
      pair_valid_q <= 1'b0;
      reject_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      tries_q      <= tries_d;
      fb_ptr_q     <= fb_ptr_d;
      parent_a_q   <= parent_a_d;
      parent_b_q   <= parent_b_d;
      fallback_q   <= fallback_d;
      pair_valid_q <= pair_valid_d;
      reject_cnt_q <= reject_cnt_d;
    end
  end

  assign pair_valid = pair_valid_q;
  assign parent_a   = parent_a_q;
  assign parent_b   = parent_b_q;
  assign fallback   = fallback_q;
  assign busy       = (state_q != IDLE);
  assign reject_cnt = reject_cnt_q;

endmodule

// File: tb/tb_parent_pair_picker.sv
// Bench for parent_pair_picker: cycle model of the pair-picking rules plus
// directed scenarios with literal expectations.
module tb_parent_pair_picker;
  localparam int IDX_W = 5, POP = 20, MAXT = 8;

  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, pair_ready = 1'b0;
  logic [IDX_W-1:0] rand_a = '0, rand_b = '0;
  logic pair_valid, fallback, busy;
  logic [IDX_W-1:0] parent_a, parent_b;
  logic [15:0] reject_cnt;

  parent_pair_picker #(.IDX_W(IDX_W), .POP_SIZE(POP), .MAX_TRIES(MAXT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rand_a(rand_a), .rand_b(rand_b),
    .pair_valid(pair_valid), .pair_ready(pair_ready), .parent_a(parent_a),
    .parent_b(parent_b), .fallback(fallback), .busy(busy), .reject_cnt(reject_cnt));

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: phase 0=waiting, 1=drawing, 2=presenting a pair.
  int m_phase, m_tries, m_fb, m_rej, m_a, m_b, m_flag;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_tries = 0; m_fb = 0; m_rej = 0; m_a = 0; m_b = 0; m_flag = 0;
    end else begin
      case (m_phase)
        0: if (req) begin m_phase = 1; m_tries = 0; end
        1: begin
          if (int'(rand_a) < POP && int'(rand_b) < POP && rand_a != rand_b) begin
            m_a = int'(rand_a); m_b = int'(rand_b); m_flag = 0; m_phase = 2;
          end else begin
            if (m_rej < 65535) m_rej = m_rej + 1;
            if (m_tries == MAXT - 1) begin
              m_a = m_fb; m_b = (m_fb + 1) % POP; m_flag = 1;
              m_fb = (m_fb + 1) % POP; m_phase = 2;
            end else m_tries = m_tries + 1;
          end
        end
        default: if (pair_ready) begin m_phase = req ? 1 : 0; m_tries = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pair_valid", int'(pair_valid), int'(m_phase == 2));
      check("busy", int'(busy), int'(m_phase != 0));
      check("parent_a", int'(parent_a), m_a);
      check("parent_b", int'(parent_b), m_b);
      check("fallback", int'(fallback), m_flag);
      check("reject_cnt", int'(reject_cnt), m_rej);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic release_pair();
    pair_ready = 1'b1; req = 1'b0;
    tick(1);
    pair_ready = 1'b0;
  endtask

  task automatic do_fallback(input int exp_a, input int exp_b, input bit lit);
    rand_a = 5'd25; rand_b = 5'd1; req = 1'b1; pair_ready = 1'b0;
    tick(1 + MAXT);
    if (lit) begin
      check("fb_valid", int'(pair_valid), 1);
      check("fb_a", int'(parent_a), exp_a);
      check("fb_b", int'(parent_b), exp_b);
      check("fb_flag", int'(fallback), 1);
    end
    release_pair();
  endtask

  initial begin
    int guard;
    tick(2);
    rst_n = 1'b1; chk_en = 1'b1;
    check("rst_valid", int'(pair_valid), 0);
    check("rst_rej", int'(reject_cnt), 0);

    // Good first draw: pair two edges after req.
    rand_a = 5'd3; rand_b = 5'd7; req = 1'b1;
    tick(1);
    check("lat_valid0", int'(pair_valid), 0);
    check("lat_busy", int'(busy), 1);
    tick(1);
    check("t1_valid", int'(pair_valid), 1);
    check("t1_a", int'(parent_a), 3);
    check("t1_b", int'(parent_b), 7);
    check("t1_rej", int'(reject_cnt), 0);
    release_pair();
    check("t1_idle", int'(busy), 0);

    // Two equal draws then a good one.
    rand_a = 5'd5; rand_b = 5'd5; req = 1'b1;
    tick(3);
    check("t2_rej", int'(reject_cnt), 2);
    check("t2_wait", int'(pair_valid), 0);
    rand_a = 5'd4; rand_b = 5'd9;
    tick(1);
    check("t2_a", int'(parent_a), 4);
    check("t2_b", int'(parent_b), 9);
    check("t2_fb", int'(fallback), 0);
    release_pair();

    // Fallback pairs rotate through the population and wrap.
    do_fallback(0, 1, 1'b1);
    check("t3_rej", int'(reject_cnt), 10);
    do_fallback(1, 2, 1'b1);
    for (int i = 2; i < 19; i++) do_fallback(i, i + 1, 1'b0);
    do_fallback(19, 0, 1'b1);

    // Pair stays stable while held and draws change.
    rand_a = 5'd10; rand_b = 5'd11; req = 1'b1;
    tick(2);
    for (int i = 0; i < 5; i++) begin
      rand_a = 5'($urandom_range(0, 31)); rand_b = 5'($urandom_range(0, 31));
      tick(1);
      check("hold_a", int'(parent_a), 10);
      check("hold_b", int'(parent_b), 11);
    end
    release_pair();
    check("hold_idle_busy", int'(busy), 0);
    check("hold_idle_valid", int'(pair_valid), 0);

    // Streaming: pair_valid toggles, pair equals the preceding draw.
    req = 1'b1; pair_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      rand_a = 5'(c); rand_b = 5'(c + 1);
      tick(1);
      check("stream_valid", int'(pair_valid), c % 2);
      if (c % 2 == 1) check("stream_a", int'(parent_a), c);
    end
    req = 1'b0;
    tick(1);
    pair_ready = 1'b0;

    // Reset while holding.
    rand_a = 5'd2; rand_b = 5'd3; req = 1'b1;
    tick(2);
    check("pre_rst_valid", int'(pair_valid), 1);
    rst_n = 1'b0; req = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("rst2_valid", int'(pair_valid), 0);
    check("rst2_busy", int'(busy), 0);
    check("rst2_rej", int'(reject_cnt), 0);
    tick(1);
    do_fallback(0, 1, 1'b1);

    // Saturate reject_cnt.
    chk_en = 1'b0;
    rand_a = 5'd25; rand_b = 5'd25; req = 1'b1; pair_ready = 1'b1;
    guard = 0;
    while (m_rej < 65535 && guard < 80000) begin tick(1); guard++; end
    check("sat_guard", int'(guard < 80000), 1);
    chk_en = 1'b1;
    tick(20);
    check("sat_rej", int'(reject_cnt), 65535);
    req = 1'b0;
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
